serpario_expander: RTL
======================

SERPARIO_EXPANDER -- requirements
Module: serpario_expander

Interface
REQ-001 The block SHALL have parameter OUT_BITS, default 8, the number of 74HC595-type output stages in the chain (1..64).
REQ-002 The block SHALL have parameter IN_BITS, default 8, the number of 74HC165-type input stages in the chain (1..64).
REQ-003 The block SHALL have parameter CLK_DIV, default 2, the clk_i cycles per half period of sh_clk_o (>=1).
REQ-004 The block SHALL have parameter REFRESH_CYCLES, default 0, the idle cycles before an automatic transfer (0 = disabled).
REQ-005 The block SHALL have port clk_i, input, 1 bit, the single system clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-007 The block SHALL have port wr_data_i, input, OUT_BITS bits, the output word.
REQ-008 The block SHALL have port wr_valid_i, input, 1 bit, a transfer request.
REQ-009 The block SHALL have port wr_ready_o, output, 1 bit, high when idle and able to accept.
REQ-010 The block SHALL have port rd_data_o, output, IN_BITS bits, the last sampled input word.
REQ-011 The block SHALL have port rd_valid_o, output, 1 bit, a one-cycle completion pulse.
REQ-012 The block SHALL have port oe_i, input, 1 bit, the output-enable request.
REQ-013 The block SHALL have port busy_o, output, 1 bit, high while a transfer is in progress.
REQ-014 The block SHALL have port ser_in_i, input, 1 bit, the serial data from the 165 chain.
REQ-015 The block SHALL have port ser_out_o, output, 1 bit, the serial data to the 595 chain.
REQ-016 The block SHALL have port sh_clk_o, output, 1 bit, the shift clock.
REQ-017 The block SHALL have port store_o, output, 1 bit, the 595 storage latch clock.
REQ-018 The block SHALL have port load_n_o, output, 1 bit, the active-low 165 parallel load.
REQ-019 The block SHALL have port out_en_n_o, output, 1 bit, the active-low 595 output enable.

Function
REQ-020 A transfer SHALL start on a cycle in which wr_valid_i and wr_ready_o are both high; wr_data_i is captured on that cycle and wr_ready_o goes low on the next cycle.
REQ-021 N = max(OUT_BITS, IN_BITS); the FSM SHALL sequence IDLE -> LOAD -> LOAD_REL -> SHIFT_LO/SHIFT_HI (N times) -> LATCH -> DONE -> IDLE, with every non-IDLE/DONE state lasting CLK_DIV cycles.
REQ-022 In LOAD, load_n_o SHALL be 0; it SHALL be 1 in every other state.
REQ-023 In SHIFT_LO, sh_clk_o SHALL be 0 and ser_out_o SHALL hold the current bit; in SHIFT_HI, sh_clk_o SHALL be 1.
REQ-024 N-OUT_BITS zeros SHALL be shifted out first, then wr_data bits OUT_BITS-1 down to 0.
REQ-025 ser_in_i SHALL be sampled on the last cycle of each SHIFT_LO; the first IN_BITS samples form rd_data, first sample = bit IN_BITS-1, and later samples are discarded.
REQ-026 In LATCH, store_o SHALL be 1; it SHALL be 0 otherwise.
REQ-027 In DONE, rd_data_o SHALL update and rd_valid_o SHALL pulse high for exactly one cycle; the FSM SHALL return to IDLE next cycle.
REQ-028 Latency from the accept cycle to the rd_valid_o cycle SHALL be (2N+3)*CLK_DIV+1 cycles.
REQ-029 out_en_n_o SHALL be 1 until the first LATCH completes, and afterwards SHALL equal ~oe_i (registered, 1-cycle delay).
REQ-030 With REFRESH_CYCLES>0, after REFRESH_CYCLES consecutive IDLE cycles without a request, the block SHALL self-start a transfer using the last accepted word (zeros if none); an external request in the same cycle SHALL take priority and restart the idle count.
REQ-031 wr_valid_i while busy SHALL be ignored (no queuing).
REQ-032 busy_o SHALL equal ~wr_ready_o.

Reset
REQ-033 While reset_n=0, the block SHALL drive: state IDLE, sh_clk_o=0, store_o=0, load_n_o=1, out_en_n_o=1, ser_out_o=0, wr_ready_o=1, busy_o=0, rd_valid_o=0, rd_data_o=0, stored word=0, and refresh counter=0.
REQ-034 Reset asserted mid-transfer SHALL abort it immediately without a store_o pulse; the 595 outputs stay disabled until the next completed LATCH.

Structure
REQ-035 The FSM state enum and the clog2 width helper SHALL live in serpario_pkg.
REQ-036 The CLK_DIV phase timer SHALL be the sub-module serpario_phase_timer, which emits a phase-end strobe.

Verification
REQ-037 With OUT_BITS=IN_BITS=8 and CLK_DIV=2, writing 0xA5 with a bench 165 model holding 0x3C SHALL shift ser_out pattern 1,0,1,0,0,1,0,1, produce rd_data_o=0x3C, and pulse rd_valid_o 39 cycles after accept.
REQ-038 With OUT_BITS=4, IN_BITS=12 and CLK_DIV=1, writing 0xF SHALL shift 8 zeros then 1,1,1,1; rd_data_o SHALL equal the 12-bit model value; latency SHALL be 28 cycles.
REQ-039 After reset, out_en_n_o SHALL stay 1 with oe_i=1 until the first store_o falls, then go 0; oe_i=0 SHALL return it to 1 one cycle later.
REQ-040 With REFRESH_CYCLES=10, after one write of 0x81, idle for 10 cycles SHALL self-start a transfer resending 0x81, and wr_valid_i raised on the expiry cycle SHALL win.
REQ-041 Pulling reset_n low during bit 3 of a shift SHALL give all outputs their reset values asynchronously with no store_o pulse, and a following write SHALL complete normally.

Source files
------------

// File: rtl/serpario_pkg.sv
// Shared types for the serial/parallel expander.
// FSM state encoding and a width helper.
package serpario_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_REL,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH,
    ST_DONE
  } state_e;

  // $clog2 that never returns 0, so counters
  // always get at least one bit.
  function automatic int clog2w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serpario_phase_timer.sv
// Phase timer: counts CLK_DIV cycles while enabled.
// Ports: clk_i, reset_n, en_i in; end_o = last cycle of a phase.
module serpario_phase_timer
  import serpario_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic en_i,
  output logic end_o
);

  localparam int W = clog2w(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] r_cnt;

  assign end_o = en_i && (r_cnt == LAST);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!en_i || end_o) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serpario_expander.sv
// 74HC595 / 74HC165 chain driver: one word out, one word in per transfer.
// Ports: wr_* request, rd_* result, oe_i/busy_o, and the chain pins.
module serpario_expander
  import serpario_pkg::*;
#(
  parameter int OUT_BITS       = 8,
  parameter int IN_BITS        = 8,
  parameter int CLK_DIV        = 2,
  parameter int REFRESH_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                reset_n,
  input  logic [OUT_BITS-1:0] wr_data_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  output logic [IN_BITS-1:0]  rd_data_o,
  output logic                rd_valid_o,
  input  logic                oe_i,
  output logic                busy_o,
  input  logic                ser_in_i,
  output logic                ser_out_o,
  output logic                sh_clk_o,
  output logic                store_o,
  output logic                load_n_o,
  output logic                out_en_n_o
);

  localparam int N  = (OUT_BITS > IN_BITS) ? OUT_BITS : IN_BITS;
  localparam int BW = clog2w(N);
  localparam int RW = clog2w(REFRESH_CYCLES + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_CYCLES);

  state_e r_state;
  state_e w_next;

  logic [OUT_BITS-1:0] r_word;
  logic [N-1:0]        r_sout;
  logic [IN_BITS-1:0]  r_sin;
  logic [IN_BITS-1:0]  r_rd_data;
  logic [BW-1:0]       r_bit;
  logic [RW-1:0]       r_refresh;
  logic                r_latched;
  logic                r_oe_n;
  logic                r_sh_clk;
  logic                r_store;
  logic                r_load_n;

  logic w_pe;
  logic w_tmr_en;
  logic w_idle;
  logic w_accept;
  logic w_fire;
  logic w_start;
  logic w_lo_end;
  logic w_hi_end;
  logic w_latch_end;
  logic [OUT_BITS-1:0] w_word;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_tmr_en = !w_idle && (r_state != ST_DONE);
  assign w_accept = w_idle && wr_valid_i;
  // Auto refresh only fires when no external request competes.
  assign w_fire   = (REFRESH_CYCLES > 0) && w_idle && !wr_valid_i
                    && (r_refresh == REF_MAX);
  assign w_start  = w_accept || w_fire;
  assign w_word   = w_accept ? wr_data_i : r_word;

  assign w_lo_end    = w_pe && (r_state == ST_SHIFT_LO);
  assign w_hi_end    = w_pe && (r_state == ST_SHIFT_HI);
  assign w_latch_end = w_pe && (r_state == ST_LATCH);

  serpario_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .en_i    (w_tmr_en),
    .end_o   (w_pe)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_start) w_next = ST_LOAD;
      ST_LOAD:     if (w_pe) w_next = ST_LOAD_REL;
      ST_LOAD_REL: if (w_pe) w_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_pe) w_next = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (w_pe) begin
          w_next = (r_bit == LAST_BIT) ? ST_LATCH : ST_SHIFT_LO;
        end
      end
      ST_LATCH:    if (w_pe) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Chain clocks are registered from next state so they never glitch.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_clk <= 1'b0;
      r_store  <= 1'b0;
      r_load_n <= 1'b1;
    end else begin
      r_sh_clk <= (w_next == ST_SHIFT_HI);
      r_store  <= (w_next == ST_LATCH);
      r_load_n <= (w_next != ST_LOAD);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_word    <= '0;
      r_sout    <= '0;
      r_sin     <= '0;
      r_rd_data <= '0;
      r_bit     <= '0;
    end else begin
      if (w_accept) r_word <= wr_data_i;
      if (w_start) begin
        // Zero-extension puts the N-OUT_BITS pad zeros first.
        r_sout <= N'(w_word);
        r_bit  <= '0;
      end else if (w_hi_end) begin
        r_sout <= r_sout << 1;
        r_bit  <= r_bit + 1'b1;
      end
      if (w_lo_end && (int'(r_bit) < IN_BITS)) begin
        r_sin <= (r_sin << 1) | IN_BITS'(ser_in_i);
      end
      if (w_latch_end) r_rd_data <= r_sin;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_refresh <= '0;
      r_latched <= 1'b0;
      r_oe_n    <= 1'b1;
    end else begin
      if (!w_idle || w_start) begin
        r_refresh <= '0;
      end else if (r_refresh != REF_MAX) begin
        r_refresh <= r_refresh + 1'b1;
      end
      if (w_latch_end) r_latched <= 1'b1;
      // Outputs stay off until the 595 holds valid data.
      r_oe_n <= (r_latched || w_latch_end) ? ~oe_i : 1'b1;
    end
  end

  assign wr_ready_o = w_idle;
  assign busy_o     = ~w_idle;
  assign rd_valid_o = (r_state == ST_DONE);
  assign rd_data_o  = r_rd_data;
  assign sh_clk_o   = r_sh_clk;
  assign store_o    = r_store;
  assign load_n_o   = r_load_n;
  assign out_en_n_o = r_oe_n;
  assign ser_out_o  = ((r_state == ST_SHIFT_LO) ||
                       (r_state == ST_SHIFT_HI)) && r_sout[N-1];

endmodule
